// File: rtl/cgra_pkg.sv
// cgra_pkg: shared widths, FIFO entry layout and collector FSM states
package cgra_pkg;
    localparam int CGRA_DW    = 16;
    localparam int CGRA_NLANE = 4;
    localparam int LANE_W     = 2;

    typedef struct packed {
        logic [LANE_W-1:0]  lane;
        logic [CGRA_DW-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, SAMPLE, SERIAL, DRAIN} state_t;
endpackage

// File: rtl/cgra_sync_fifo.sv
// cgra_sync_fifo: show-ahead synchronous FIFO with full/empty from extra-MSB pointers
//   clk, rst   clock, synchronous active-high reset
//   push/wdata write request (ignored when full)
//   pop        read request (ignored when empty)
//   rdata      head entry, zero while empty
//   full/empty occupancy flags derived from the registered pointers
module cgra_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle never frees room for a push: full gates push on its own.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/cgra_out_collector.sv
// cgra_out_collector: snapshots CGRA result lanes and streams enabled lanes out through a FIFO
//   clk, rst              clock, synchronous active-high reset
//   start                 command strobe, honoured only when idle
//   sample_num, lane_mask snapshot count and lane enables, latched on accepted start
//   data_in0..3           array result lanes
//   out_data, out_lane    FIFO head word and its lane index
//   out_valid, out_ready  output handshake
//   busy                  command in progress
//   done                  one-cycle completion pulse
module cgra_out_collector
    import cgra_pkg::*;
#(
    parameter int DW    = CGRA_DW,
    parameter int NLANE = CGRA_NLANE,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] sample_num,
    input  logic [NLANE-1:0] lane_mask,
    input  logic [DW-1:0]    data_in0,
    input  logic [DW-1:0]    data_in1,
    input  logic [DW-1:0]    data_in2,
    input  logic [DW-1:0]    data_in3,
    output logic [DW-1:0]    out_data,
    output logic [LANE_W-1:0] out_lane,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    state_t              state, state_n;
    logic [CNT_W-1:0]    remaining, remaining_n;
    logic [NLANE-1:0]    mask, mask_n;
    logic [LANE_W-1:0]   lane_idx, lane_idx_n;
    logic [DW-1:0]       snap [NLANE];
    logic                done_n, snap_en, push, full, empty, lane_en;
    logic [LANE_W+DW-1:0] head;

    assign lane_en   = mask[lane_idx];
    assign busy      = state != IDLE;
    assign out_valid = !empty;
    assign out_lane  = head[LANE_W+DW-1:DW];
    assign out_data  = head[DW-1:0];

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        mask_n      = mask;
        lane_idx_n  = lane_idx;
        done_n      = 1'b0;
        snap_en     = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    remaining_n = sample_num;
                    mask_n      = lane_mask;
                    // Empty commands complete immediately without ever going busy.
                    if (sample_num == '0 || lane_mask == '0) done_n = 1'b1;
                    else state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                snap_en     = 1'b1;
                remaining_n = remaining - CNT_W'(1);
                lane_idx_n  = '0;
                state_n     = SERIAL;
            end
            SERIAL: begin
                push = lane_en && !full;
                // Masked lanes still cost a cycle, keeping the sample period fixed at 5.
                if (!lane_en || !full) begin
                    lane_idx_n = lane_idx + LANE_W'(1);
                    if (lane_idx == LANE_W'(NLANE-1)) state_n = (remaining != '0) ? SAMPLE : DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            mask      <= '0;
            lane_idx  <= '0;
            done      <= 1'b0;
            for (int i = 0; i < NLANE; i++) snap[i] <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            mask      <= mask_n;
            lane_idx  <= lane_idx_n;
            done      <= done_n;
            if (snap_en) begin
                snap[0] <= data_in0;
                snap[1] <= data_in1;
                snap[2] <= data_in2;
                snap[3] <= data_in3;
            end
        end
    end

    cgra_sync_fifo #(
        .DEPTH(DEPTH),
        .W    (LANE_W + DW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata({lane_idx, snap[lane_idx]}),
        .pop  (out_valid && out_ready),
        .rdata(head),
        .full (full),
        .empty(empty)
    );
endmodule
